// File: rtl/confreg_pkg.sv
// ============================================================================
// confreg_pkg : register offsets, window width and byte-merge helper
// Rev 1.0
// ============================================================================
`default_nettype none

package confreg_pkg;

  localparam int HIT_W = 16;

  localparam logic [15:0] CR0_OFF     = 16'h8000;
  localparam logic [15:0] CR1_OFF     = 16'h8004;
  localparam logic [15:0] CR2_OFF     = 16'h8008;
  localparam logic [15:0] CR3_OFF     = 16'h800C;
  localparam logic [15:0] CR4_OFF     = 16'h8010;
  localparam logic [15:0] CR5_OFF     = 16'h8014;
  localparam logic [15:0] CR6_OFF     = 16'h8018;
  localparam logic [15:0] CR7_OFF     = 16'h801C;
  localparam logic [15:0] TIMER_OFF   = 16'hE000;
  localparam logic [15:0] COMPARE_OFF = 16'hE004;
  localparam logic [15:0] LED_OFF     = 16'hF000;
  localparam logic [15:0] NUM_OFF     = 16'hF010;
  localparam logic [15:0] SWITCH_OFF  = 16'hF020;
  localparam logic [15:0] SIMU_OFF    = 16'hF030;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/confreg_timer.sv
// ============================================================================
// confreg_timer : free-running TIMER, COMPARE and level compare interrupt
// Rev 1.0
// ============================================================================
`default_nettype none

module confreg_timer
  import confreg_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        timer_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  input  logic [3:0]  wen,
  output logic [31:0] timer,
  output logic [31:0] compare,
  output logic        timer_int
);

  logic [31:0] timer_q, timer_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  always_comb begin
    timer_d     = timer_q + 32'd1;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (timer_we) timer_d = byte_merge(timer_q, wdata, wen);
    if (timer_q == compare_q && compare_q != 32'd0) timer_int_d = 1'b1;
    // A COMPARE write acknowledges the interrupt and beats a same-cycle match.
    if (compare_we) begin
      compare_d   = byte_merge(compare_q, wdata, wen);
      timer_int_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q     <= '0;
      compare_q   <= '0;
      timer_int_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign timer     = timer_q;
  assign compare   = compare_q;
  assign timer_int = timer_int_q;

endmodule

`default_nettype wire

// File: rtl/sram_confreg_responder.sv
// ============================================================================
// sram_confreg_responder : data-SRAM responder serving the config window
// locally and passing every other access through to the data RAM.  Rev 1.0
// ============================================================================
`default_nettype none

module sram_confreg_responder
  import confreg_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'hBFAF_0000,
  parameter bit          SIMULATION = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic        timer_int
);

  localparam logic [31:0] SIMU_VAL = SIMULATION ? 32'hFFFF_FFFF : 32'h0;

  logic        hit, rd_en, wr;
  logic [13:0] off_w;
  logic        sel_cr;
  logic [2:0]  cr_idx;
  logic [31:0] rd_val;
  logic [31:0] timer, compare;

  logic [31:0] cr_q [8];
  logic [31:0] cr_d [8];
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [7:0]  sw_meta_q, sw_meta_d;
  logic [7:0]  sw_sync_q, sw_sync_d;
  logic        hit_q, hit_d;
  logic [31:0] conf_rdata_q, conf_rdata_d;

  assign hit    = cpu_addr[31 -: HIT_W] == ADDR_BASE[31 -: HIT_W];
  assign off_w  = cpu_addr[15:2];
  assign rd_en  = cpu_en & hit;
  assign wr     = cpu_en & hit & (|cpu_wen);
  assign sel_cr = off_w[13:3] == CR0_OFF[15:5];
  assign cr_idx = off_w[2:0];

  assign ram_en    = cpu_en & ~hit;
  assign ram_wen   = cpu_wen;
  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;

  confreg_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .timer_we   (wr && off_w == TIMER_OFF[15:2]),
    .compare_we (wr && off_w == COMPARE_OFF[15:2]),
    .wdata      (cpu_wdata),
    .wen        (cpu_wen),
    .timer      (timer),
    .compare    (compare),
    .timer_int  (timer_int)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cr_d[i] = cr_q[i];
      if (wr && sel_cr && cr_idx == 3'(i)) cr_d[i] = byte_merge(cr_q[i], cpu_wdata, cpu_wen);
    end

    led_d = led_q;
    if (wr && off_w == LED_OFF[15:2]) begin
      if (cpu_wen[0]) led_d[7:0]  = cpu_wdata[7:0];
      if (cpu_wen[1]) led_d[15:8] = cpu_wdata[15:8];
    end

    num_d = num_q;
    if (wr && off_w == NUM_OFF[15:2]) num_d = byte_merge(num_q, cpu_wdata, cpu_wen);

    sw_meta_d = switch;
    sw_sync_d = sw_meta_q;

    // Read mux sees pre-edge register values, so read-during-write returns old data.
    rd_val = '0;
    if (sel_cr) begin
      rd_val = cr_q[cr_idx];
    end else begin
      case (off_w)
        TIMER_OFF[15:2]:   rd_val = timer;
        COMPARE_OFF[15:2]: rd_val = compare;
        LED_OFF[15:2]:     rd_val = {16'h0, led_q};
        NUM_OFF[15:2]:     rd_val = num_q;
        SWITCH_OFF[15:2]:  rd_val = {24'h0, sw_sync_q};
        SIMU_OFF[15:2]:    rd_val = SIMU_VAL;
        default:           rd_val = '0;
      endcase
    end

    hit_d        = cpu_en ? hit : hit_q;
    conf_rdata_d = rd_en ? rd_val : conf_rdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) cr_q[i] <= '0;
      led_q        <= '0;
      num_q        <= '0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      hit_q        <= 1'b1;
      conf_rdata_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) cr_q[i] <= cr_d[i];
      led_q        <= led_d;
      num_q        <= num_d;
      sw_meta_q    <= sw_meta_d;
      sw_sync_q    <= sw_sync_d;
      hit_q        <= hit_d;
      conf_rdata_q <= conf_rdata_d;
    end
  end

  assign cpu_rdata = hit_q ? conf_rdata_q : ram_rdata;
  assign led       = led_q;
  assign num_data  = num_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_confreg_responder.sv
// ============================================================================
// tb_sram_confreg_responder : directed vectors with a read-data scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_confreg_responder;

  localparam logic [31:0] A_CR3  = 32'hBFAF_800C;
  localparam logic [31:0] A_TMR  = 32'hBFAF_E000;
  localparam logic [31:0] A_CMP  = 32'hBFAF_E004;
  localparam logic [31:0] A_LED  = 32'hBFAF_F000;
  localparam logic [31:0] A_NUM  = 32'hBFAF_F010;
  localparam logic [31:0] A_SW   = 32'hBFAF_F020;
  localparam logic [31:0] A_SIMU = 32'hBFAF_F030;
  localparam logic [31:0] A_HOLE = 32'hBFAF_F040;
  localparam logic [31:0] A_RAM  = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [7:0]  switch;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_int;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q [$];
  string       name_q [$];
  bit          rd_chk  = 1'b0;
  bit          rsp_due = 1'b0;
  logic [31:0] mon_exp;
  string       mon_name;

  always #5 clk = ~clk;

  sram_confreg_responder dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_en    (cpu_en),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_en    (ram_en),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .switch    (switch),
    .led       (led),
    .num_data  (num_data),
    .timer_int (timer_int)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Response is owed on the cycle after a checked request is accepted.
  always @(posedge clk) rsp_due <= rd_chk & cpu_en & resetn;

  always @(negedge clk) begin
    if (rsp_due) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %h want none", cpu_rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, cpu_rdata, mon_exp);
      end
    end
  end

  // Called at posedge+1; returns at the posedge+1 after the request is taken.
  task automatic req(input string name, input logic [31:0] addr, input logic [3:0] wen,
                     input logic [31:0] wdata, input bit chk, input logic [31:0] exp,
                     input logic exp_ram_en);
    cpu_en    = 1'b1;
    cpu_addr  = addr;
    cpu_wen   = wen;
    cpu_wdata = wdata;
    rd_chk    = chk;
    if (chk) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    #1;
    check({name, "_ram_en"}, {31'h0, ram_en}, {31'h0, exp_ram_en});
    if (exp_ram_en) check({name, "_ram_addr"}, ram_addr, addr);
    @(posedge clk); #1;
    cpu_en  = 1'b0;
    cpu_wen = 4'h0;
    rd_chk  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cpu_en    = 1'b0;
    cpu_wen   = 4'h0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ram_rdata = '0;
    switch    = 8'h00;
    @(posedge clk); #1;
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_int", {31'h0, timer_int}, 32'h0);
    idle(1);
    resetn = 1'b1;
    idle(1);

    // scratch register, byte-lane LED, NUM, RO and unmapped accesses
    req("cr3_wr", A_CR3, 4'hF, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
    req("cr3_rd", A_CR3, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
    idle(2);
    check("idle_hold", cpu_rdata, 32'h1234_5678);
    req("led_wr", A_LED, 4'b0001, 32'hFFFF_FFA5, 1'b0, 32'h0, 1'b0);
    check("led_out", {16'h0, led}, 32'h0000_00A5);
    req("led_rd", A_LED, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
    req("num_wr", A_NUM, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0);
    check("num_out", num_data, 32'hCAFE_F00D);
    req("sw_wr", A_SW, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    req("sw_rd", A_SW, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    req("hole_wr", A_HOLE, 4'hF, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
    req("hole_rd", A_HOLE, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    req("simu_rd", A_SIMU, 4'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // pass-through to RAM, then back to a local read
    ram_rdata = 32'hDEAD_BEEF;
    req("ram_rd", A_RAM, 4'h0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    req("cr3_rd2", A_CR3, 4'h0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);

    // timer wrap and compare interrupt
    req("tmr_wr", A_TMR, 4'hF, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
    req("cmp_wr", A_CMP, 4'hF, 32'h0000_0002, 1'b0, 32'h0, 1'b0);
    idle(3);
    check("int_early", {31'h0, timer_int}, 32'h0);
    idle(1);
    check("int_rise", {31'h0, timer_int}, 32'h1);
    req("tmr_rd_wrap", A_TMR, 4'h0, 32'h0, 1'b1, 32'h0000_0003, 1'b0);
    req("cmp_clr", A_CMP, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0);
    check("int_clr", {31'h0, timer_int}, 32'h0);
    idle(10);
    check("int_stay_clr", {31'h0, timer_int}, 32'h0);

    // read-during-write on TIMER returns the pre-write count
    req("tmr_wr50", A_TMR, 4'hF, 32'h0000_0050, 1'b0, 32'h0, 1'b0);
    req("tmr_rdw", A_TMR, 4'hF, 32'h0000_0100, 1'b1, 32'h0000_0050, 1'b0);
    req("tmr_rd100", A_TMR, 4'h0, 32'h0, 1'b1, 32'h0000_0100, 1'b0);

    // raise the interrupt so reset has something to clear
    req("tmr_wr10", A_TMR, 4'hF, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
    req("cmp_wr12", A_CMP, 4'hF, 32'h0000_0012, 1'b0, 32'h0, 1'b0);
    idle(2);
    check("int_rise2", {31'h0, timer_int}, 32'h1);

    // asynchronous reset in the middle of a NUM write
    cpu_en    = 1'b1;
    cpu_addr  = A_NUM;
    cpu_wen   = 4'hF;
    cpu_wdata = 32'h1111_1111;
    switch    = 8'hA5;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_num", num_data, 32'h0);
    check("arst_led", {16'h0, led}, 32'h0);
    check("arst_int", {31'h0, timer_int}, 32'h0);
    check("arst_rdata", cpu_rdata, 32'h0);
    cpu_en  = 1'b0;
    cpu_wen = 4'h0;
    idle(2);
    resetn = 1'b1;
    req("sw_rd_r1", A_SW, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    idle(1);
    req("sw_rd_r3", A_SW, 4'h0, 32'h0, 1'b1, 32'h0000_00A5, 1'b0);
    req("num_rd_rst", A_NUM, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
    idle(2);
    check("sb_drain", exp_q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_confreg_responder.md
Name: sram_confreg_responder

Overview:
- Responder side of the CPU data-SRAM interface: accepts en/wen/addr/wdata requests and returns rdata with 1-cycle latency.
- Requests inside the config-register window are served locally: scratch regs, LED, numeric display, switches, timer/compare with interrupt.
- All other requests pass through unchanged to the external data RAM port.
- Sits between the CPU data port and the data RAM in the SoC top.

Parameters:
- ADDR_BASE, 32'hBFAF_0000, window base; hit when cpu_addr[31:16] == ADDR_BASE[31:16].
- SIMULATION, 1, value reported by SIMU_FLAG (all ones if 1, else 0).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- cpu_en  in  1  request valid this cycle.
- cpu_wen  in  4  byte write enables; 0 = read.
- cpu_addr  in  32  byte address, word-aligned; [1:0] ignored.
- cpu_wdata  in  32  write data, byte lanes per cpu_wen.
- cpu_rdata  out  32  read data, valid the cycle after the request.
- ram_en  out  1  RAM request enable.
- ram_wen  out  4  RAM byte enables.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, 1-cycle latency.
- switch  in  8  asynchronous board switches.
- led  out  16  LED register.
- num_data  out  32  seven-segment display value.
- timer_int  out  1  timer-compare interrupt, level.

Behaviour:
- Decode: hit = cpu_addr[31:16] == ADDR_BASE[31:16]; off = cpu_addr[15:0].
- Pass-through: ram_en = cpu_en & ~hit. ram_wen, ram_addr and ram_wdata are driven combinationally from the cpu_* inputs.
- Register map (offset, access):
  - 0x8000–0x801C: CR0–CR7, RW.
  - 0xE000: TIMER, RW.
  - 0xE004: COMPARE, RW.
  - 0xF000: LED[15:0], RW; bits 31:16 read 0.
  - 0xF010: NUM, RW.
  - 0xF020: SWITCH, RO, zero-extended.
  - 0xF030: SIMU_FLAG, RO.
  - Unmapped offsets in the window read 0; writes are ignored.
- Writes: on a clock edge with cpu_en & hit & |cpu_wen, each byte lane i is updated where cpu_wen[i]=1.
- Writes to RO registers have no effect.
- Read path:
  - hit_r <= cpu_en ? hit : hit_r.
  - conf_rdata_r <= the register value sampled before any same-edge write.
  - cpu_rdata = hit_r ? conf_rdata_r : ram_rdata.
  - Read-during-write to the same register returns the old value.
- Timer:
  - Increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - A CPU write to TIMER has priority that cycle: merged bytes are loaded, no increment.
- Interrupt:
  - timer_int sets on the cycle after TIMER == COMPARE while COMPARE != 0.
  - Stays set until any write to COMPARE, which clears it.
  - Set and clear in the same cycle: clear wins.
- Switch input passes through a 2-flop synchronizer; SWITCH reads show the input 2 cycles after it changes.
- Reset (async, resetn=0): all registers, TIMER, COMPARE and timer_int are cleared; led=0, num_data=0.
  - hit_r=1 and conf_rdata_r=0, so cpu_rdata=0 during and immediately after reset.
  - Reset mid-request aborts it; no write occurs.
- Idle: with cpu_en=0, hit_r and conf_rdata_r hold, so cpu_rdata remains stable for a local read.

Decomposition:
- Package confreg_pkg holds:
  - register offset constants: CR0_OFF..CR7_OFF, TIMER_OFF, COMPARE_OFF, LED_OFF, NUM_OFF, SWITCH_OFF, SIMU_OFF;
  - the window-hit width constant (16);
  - a byte-merge function taking (old, wdata, wen).
- One sub-module, confreg_timer, contains TIMER, COMPARE, the load priority and the timer_int set/clear logic.

Test Plan:
- Read/write scratch: write CR3 (0xBFAF_800C) = 0x1234_5678 with wen=4'hF, then read -> cpu_rdata=0x1234_5678 one cycle later; ram_en=0 on both cycles.
- Byte write: write LED with wen=4'b0001, wdata=0xFFFF_FFA5 -> led=0x00A5; read LED -> 0x0000_00A5.
- Pass-through: read 0x8000_0100 with ram_rdata=0xDEAD_BEEF -> ram_en=1, ram_addr=0x8000_0100, cpu_rdata=0xDEAD_BEEF next cycle.
- Timer wrap and interrupt:
  - Write TIMER=0xFFFF_FFFE and COMPARE=0x0000_0002 -> timer_int rises 5 cycles after the TIMER write.
  - Write COMPARE=0 -> timer_int=0 next cycle; no re-assertion while COMPARE=0.
- Read-during-write: write TIMER=0x100 and read TIMER in the same cycle -> returned value is the pre-write count.
- Async reset: assert resetn=0 mid-write to NUM -> NUM, led, timer_int and cpu_rdata all read 0 immediately; after release, SWITCH=0xA5 on the input reads 0x0000_00A5 from the third edge onward.
